pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Parametrised pipeline stage register with a valid/ready handshake and an optional 2-entry skid buffer.
//  Successor to the fixed per-field stage registers: packs control and payload into two vectors.
//  Flush clears only the control field. Freeze holds the stage. Discarded instructions are counted.
//  Sits between any two pipeline stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
// PARAMETERS
//  DATA_W    128   payload width (PC, Val_Rn, Val_Rm, imm, ...); flush does not clear it
//  CTRL_W    16    control width (WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD, ...); flush loads CTRL_RST
//  CTRL_RST  0     control value after reset/flush and whenever the stage is empty; CTRL_W bits
//  SKID      1     1: 2-entry skid, in_ready registered; 0: single entry, in_ready depends on out_ready
//  CNT_W     16    width of drop_count
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous, active-low reset
//  flush       in   1       discard all held entries (branch taken)
//  freeze      in   1       hold stage; no transfer on either side (hazard stall)
//  in_valid    in   1       upstream entry valid
//  in_ready    out  1       stage accepts this cycle
//  in_ctrl     in   CTRL_W  upstream control field
//  in_data     in   DATA_W  upstream payload
//  out_valid   out  1       head entry valid to downstream
//  out_ready   in   1       downstream accepts
//  out_ctrl    out  CTRL_W  head control field
//  out_data    out  DATA_W  head payload
//  occupancy   out  2       entries held: 0..2
//  drop_count  out  CNT_W   saturating count of valid entries discarded by flush
// BEHAVIOUR
//  - Transfers: acc = in_valid & in_ready; pop = out_valid & out_ready.
//    Latency is 1 cycle from acc to out_valid.
//  - Registers:
//    - main {ctrl, data} drives out_*
//    - skid {ctrl, data}, present only when SKID=1
//    - state: EMPTY, ONE, TWO (TWO only when SKID=1)
//  - Reset (rst=0, async):
//    - state=EMPTY; main/skid ctrl=CTRL_RST; main/skid data=0; drop_count=0
//    - out_valid=0, in_ready=0 while rst low; occupancy=0
//  - Combinational outputs:
//    - out_valid = (state!=EMPTY) & ~freeze & ~flush
//    - SKID=1: in_ready = (state!=TWO) & ~freeze & ~flush
//    - SKID=0: in_ready = ((state==EMPTY) | out_ready) & ~freeze & ~flush
//    - out_ctrl = CTRL_RST whenever state==EMPTY
//  - State transitions (no flush, no freeze):
//    - EMPTY: acc -> ONE, main<=in
//    - ONE: acc&~pop -> TWO, skid<=in | acc&pop -> ONE, main<=in | pop&~acc -> EMPTY
//    - TWO: pop -> ONE, main<=skid, skid ctrl<=CTRL_RST; acc is impossible in TWO
//  - Priority: rst > flush > freeze > handshake.
//  - flush=1 (wins over freeze and handshake):
//    - next state=EMPTY; main/skid ctrl<=CTRL_RST; data registers hold
//    - no acc or pop that cycle
//    - drop_count += occupancy, saturating at 2^CNT_W-1, never wraps
//  - freeze=1 with flush=0: every register holds; in_ready=0; out_valid=0.
//  - occupancy = 0/1/2 for EMPTY/ONE/TWO.
//  - Ordering is strict FIFO; no entry is duplicated or lost except by flush.
//  - Throughput is 1 entry/cycle when out_ready is held high, for both SKID values.
// TESTING
//  1. Reset with rst=0 mid-stream at occupancy 2
//     -> same cycle out_valid=0, occupancy=0, out_ctrl=CTRL_RST, drop_count=0.
//  2. Streaming: SKID=1, out_ready=1, in_data=1,2,3,4 on consecutive cycles
//     -> out_data=1,2,3,4 one cycle later, no bubbles, occupancy stays 1.
//  3. Backpressure: SKID=1, out_ready=0, in_valid=1 with data A then B
//     -> occupancy=2 and in_ready=0; raise out_ready -> A then B, in_ready=1 the cycle after A pops.
//  4. Flush at occupancy 2, CTRL_RST=0, in_ctrl=16'hFFFF
//     -> next cycle out_valid=0, out_ctrl=0, data unchanged, drop_count +2.
//     With CNT_W=2 and drop_count=3, flush again -> drop_count stays 3.
//  5. freeze=1 for 3 cycles with occupancy 1 and in_valid=1
//     -> in_ready=0, out_valid=0, out_data stable; freeze=1 with flush=1 -> stage empties.
//  6. SKID=0, out_ready=0 at occupancy 1 -> in_ready=0; same cycle raise out_ready
//     -> in_ready=1, next entry replaces main with no bubble.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf
//   Pipeline stage register with a valid/ready handshake and an optional
//   second (skid) entry. Control and payload travel as two packed vectors.
//   Flush discards every held entry, reloads the control registers with
//   CTRL_RST and leaves the payload registers untouched. Freeze holds the
//   whole stage. Entries thrown away by flush are counted in drop_count_o.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | nothing held, out_ctrl_o forced to CTRL_RST
//   ST_ONE   | head entry in main registers
//   ST_TWO   | head in main, next entry in skid (SKID=1 only)
//
// Ports
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   flush_i       discard all held entries
//   freeze_i      hold stage, no transfer on either side
//   in_valid_i    upstream entry valid
//   in_ready_o    stage accepts this cycle
//   in_ctrl_i     upstream control field  [CTRL_W]
//   in_data_i     upstream payload        [DATA_W]
//   out_valid_o   head entry valid
//   out_ready_i   downstream accepts
//   out_ctrl_o    head control field      [CTRL_W]
//   out_data_o    head payload            [DATA_W]
//   occupancy_o   entries held, 0..2
//   drop_count_o  saturating count of entries discarded by flush [CNT_W]
// ---------------------------------------------------------------------------
module pipe_stage_buf #(
    parameter int unsigned              DATA_W   = 128,
    parameter int unsigned              CTRL_W   = 16,
    parameter logic [CTRL_W-1:0]        CTRL_RST = '0,
    parameter int unsigned              SKID     = 1,
    parameter int unsigned              CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              freeze_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  drop_count_o
);

    localparam bit HAS_SKID = (SKID != 0);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [CNT_W-1:0]    drop_q, drop_d;
    logic [CNT_W:0]      drop_sum;

    logic                not_held;
    logic                acc;
    logic                pop;

    assign not_held = ~freeze_i & ~flush_i;

    assign out_valid_o = (state_q != ST_EMPTY) & not_held;

    // rst_ni gating keeps in_ready_o low for the whole reset assertion,
    // not just after the state register has cleared.
    generate
        if (HAS_SKID) begin : g_rdy_skid
            assign in_ready_o = rst_ni & (state_q != ST_TWO) & not_held;
        end else begin : g_rdy_single
            assign in_ready_o = rst_ni & ((state_q == ST_EMPTY) | out_ready_i) & not_held;
        end
    endgenerate

    assign acc = in_valid_i & in_ready_o;
    assign pop = out_valid_o & out_ready_i;

    assign out_ctrl_o   = (state_q == ST_EMPTY) ? CTRL_RST : main_ctrl_q;
    assign out_data_o   = main_data_q;
    assign occupancy_o  = state_q;
    assign drop_count_o = drop_q;

    // One extra bit catches the carry; any carry saturates the counter.
    assign drop_sum = {1'b0, drop_q} + (CNT_W+1)'(occupancy_o);

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        drop_d      = drop_q;

        if (flush_i) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = CTRL_RST;
            skid_ctrl_d = CTRL_RST;
            drop_d      = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
        end else if (!freeze_i) begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = in_ctrl_i;
                        main_data_d = in_data_i;
                    end
                end
                ST_ONE: begin
                    if (acc && pop) begin
                        main_ctrl_d = in_ctrl_i;
                        main_data_d = in_data_i;
                    end else if (acc && HAS_SKID) begin
                        state_d     = ST_TWO;
                        skid_ctrl_d = in_ctrl_i;
                        skid_data_d = in_data_i;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready_o is low here, so only the pop side can move.
                    if (pop) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = CTRL_RST;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= CTRL_RST;
            main_data_q <= '0;
            skid_ctrl_q <= CTRL_RST;
            skid_data_q <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            drop_q      <= drop_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_buf
//   Two instances: dut_a (SKID=1, CNT_W=2, CTRL_RST=0) and dut_b (SKID=0,
//   CTRL_RST=16'h00A5). Driver tasks push each entry expected to be accepted
//   into a per-instance queue; monitors pop and compare on every output
//   transfer. Inputs change at posedge+1, handshake is sampled at posedge+4,
//   monitors sample at the falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_stage_buf;

    localparam int DW = 128;
    localparam int CW = 16;
    localparam logic [CW-1:0] B_RST = 16'h00A5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // instance A
    logic          a_flush, a_freeze, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [CW-1:0] a_in_ctrl, a_out_ctrl;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [1:0]    a_occ;
    logic [1:0]    a_drop;
    // instance B
    logic          b_flush, b_freeze, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [CW-1:0] b_in_ctrl, b_out_ctrl;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [1:0]    b_occ;
    logic [15:0]   b_drop;

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(16'h0000), .SKID(1), .CNT_W(2)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush), .freeze_i(a_freeze),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_ctrl_i(a_in_ctrl), .in_data_i(a_in_data),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_ctrl_o(a_out_ctrl), .out_data_o(a_out_data),
        .occupancy_o(a_occ), .drop_count_o(a_drop)
    );

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(B_RST), .SKID(0), .CNT_W(16)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush), .freeze_i(b_freeze),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_ctrl_i(b_in_ctrl), .in_data_i(b_in_data),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_ctrl_o(b_out_ctrl), .out_data_o(b_out_data),
        .occupancy_o(b_occ), .drop_count_o(b_drop)
    );

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } entry_t;

    entry_t qa[$];
    entry_t qb[$];
    int checks = 0;
    int errors = 0;
    int pops_a = 0;
    int pops_b = 0;

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            pops_a++;
            if (qa.size() == 0) begin
                check("a_unexpected_pop", {a_out_ctrl, a_out_data}, 144'h0);
            end else begin
                entry_t e;
                e = qa.pop_front();
                check("a_out_ctrl", a_out_ctrl, e.ctrl);
                check("a_out_data", a_out_data, e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_out_valid && b_out_ready) begin
            pops_b++;
            if (qb.size() == 0) begin
                check("b_unexpected_pop", {b_out_ctrl, b_out_data}, 144'h0);
            end else begin
                entry_t e;
                e = qb.pop_front();
                check("b_out_ctrl", b_out_ctrl, e.ctrl);
                check("b_out_data", b_out_data, e.data);
            end
        end
    end

    // ---------------- drivers ----------------
    // exp_vld / exp_occ < 0 skips that comparison.
    task automatic cyc_a(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic ordy, input logic fl, input logic fz,
                         input logic exp_rdy, input int exp_vld, input int exp_occ);
        @(posedge clk);
        #1;
        a_in_valid = v; a_in_ctrl = c; a_in_data = d;
        a_out_ready = ordy; a_flush = fl; a_freeze = fz;
        #3;
        check("a_in_ready", a_in_ready, exp_rdy);
        if (exp_vld >= 0) check("a_out_valid", a_out_valid, exp_vld[0]);
        if (exp_occ >= 0) check("a_occupancy", a_occ, exp_occ[1:0]);
        if (fl) qa.delete();
        if (v && exp_rdy) qa.push_back('{ctrl: c, data: d});
    endtask

    task automatic cyc_b(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic ordy, input logic exp_rdy, input int exp_vld, input int exp_occ);
        @(posedge clk);
        #1;
        b_in_valid = v; b_in_ctrl = c; b_in_data = d; b_out_ready = ordy;
        #3;
        check("b_in_ready", b_in_ready, exp_rdy);
        if (exp_vld >= 0) check("b_out_valid", b_out_valid, exp_vld[0]);
        if (exp_occ >= 0) check("b_occupancy", b_occ, exp_occ[1:0]);
        if (v && exp_rdy) qb.push_back('{ctrl: c, data: d});
    endtask

    localparam logic [DW-1:0] DA = 128'hAAAA_0000_0000_0000_0000_0000_0000_000A;
    localparam logic [DW-1:0] DB = 128'hBBBB_0000_0000_0000_0000_0000_0000_000B;
    localparam logic [DW-1:0] DD = 128'hDDDD_1111_2222_3333_4444_5555_6666_777D;
    localparam logic [DW-1:0] DG = 128'h6666_0000_0000_0000_0000_0000_0000_0006;
    localparam logic [DW-1:0] DI = 128'h1111_2222_0000_0000_0000_0000_0000_0001;

    initial begin
        rst_n = 1'b0;
        a_flush = 0; a_freeze = 0; a_in_valid = 1; a_in_ctrl = 16'h1234; a_in_data = '0; a_out_ready = 0;
        b_flush = 0; b_freeze = 0; b_in_valid = 1; b_in_ctrl = 16'h1234; b_in_data = '0; b_out_ready = 0;
        #3;
        check("rst_a_in_ready", a_in_ready, 1'b0);
        check("rst_a_out_valid", a_out_valid, 1'b0);
        check("rst_a_occ", a_occ, 2'd0);
        check("rst_a_drop", a_drop, 2'd0);
        check("rst_a_out_ctrl", a_out_ctrl, 16'h0000);
        check("rst_b_in_ready", b_in_ready, 1'b0);
        check("rst_b_out_ctrl", b_out_ctrl, B_RST);
        a_in_valid = 0; b_in_valid = 0;
        #9 rst_n = 1'b1;

        // streaming, no bubbles
        cyc_a(1, 16'h0101, 128'd1, 1, 0, 0, 1, 0, 0);
        cyc_a(1, 16'h0202, 128'd2, 1, 0, 0, 1, 1, 1);
        cyc_a(1, 16'h0303, 128'd3, 1, 0, 0, 1, 1, 1);
        cyc_a(1, 16'h0404, 128'd4, 1, 0, 0, 1, 1, 1);
        cyc_a(0, 16'h0000, 128'd0, 1, 0, 0, 1, 1, 1);
        cyc_a(0, 16'h0000, 128'd0, 1, 0, 0, 1, 0, 0);

        // backpressure into skid, then drain
        cyc_a(1, 16'h0A0A, DA, 0, 0, 0, 1, 0, 0);
        cyc_a(1, 16'h0B0B, DB, 0, 0, 0, 1, 1, 1);
        cyc_a(1, 16'h0C0C, 128'hC, 0, 0, 0, 0, 1, 2);
        cyc_a(1, 16'h0C0C, 128'hC, 1, 0, 0, 0, 1, 2);
        cyc_a(1, 16'h0C0C, 128'hC, 1, 0, 0, 1, 1, 1);
        cyc_a(0, 16'h0000, 128'd0, 1, 0, 0, 1, 1, 1);
        cyc_a(0, 16'h0000, 128'd0, 1, 0, 0, 1, 0, 0);

        // flush at occupancy 2: drop 0 -> 2
        cyc_a(1, 16'h0D0D, DD, 0, 0, 0, 1, 0, 0);
        cyc_a(1, 16'h0E0E, 128'hE, 0, 0, 0, 1, 1, 1);
        cyc_a(1, 16'hFFFF, 128'hF00D, 0, 1, 0, 0, 0, 2);
        cyc_a(0, 16'h0000, 128'd0, 0, 0, 0, 1, 0, 0);
        check("flush2_out_ctrl", a_out_ctrl, 16'h0000);
        check("flush2_out_data", a_out_data, DD);
        check("flush2_drop", a_drop, 2'd2);

        // flush at occupancy 1: drop 2 -> 3 (exact maximum)
        cyc_a(1, 16'h0F0F, 128'hF, 0, 0, 0, 1, 0, 0);
        cyc_a(0, 16'hFFFF, 128'd0, 0, 1, 0, 0, 0, 1);
        cyc_a(0, 16'h0000, 128'd0, 0, 0, 0, 1, 0, 0);
        check("flush1_drop", a_drop, 2'd3);

        // flush at occupancy 2 while saturated: stays 3
        cyc_a(1, 16'h0606, DG, 0, 0, 0, 1, 0, 0);
        cyc_a(1, 16'h0707, 128'h7, 0, 0, 0, 1, 1, 1);
        cyc_a(1, 16'hFFFF, 128'd0, 0, 1, 0, 0, 0, 2);
        cyc_a(0, 16'h0000, 128'd0, 0, 0, 0, 1, 0, 0);
        check("sat_drop", a_drop, 2'd3);
        check("sat_out_data", a_out_data, DG);

        // freeze holds the stage, then freeze+flush empties it
        cyc_a(1, 16'h0909, DI, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc_a(1, 16'h0808, 128'h8, 1, 0, 1, 0, 0, 1);
            check("freeze_out_data", a_out_data, DI);
        end
        cyc_a(1, 16'h0808, 128'h8, 1, 1, 1, 0, 0, 1);
        cyc_a(0, 16'h0000, 128'd0, 1, 0, 0, 1, 0, 0);

        // async reset mid-stream at occupancy 2
        cyc_a(1, 16'h0505, 128'h5, 0, 0, 0, 1, 0, 0);
        cyc_a(1, 16'h0404, 128'h44, 0, 0, 0, 1, 1, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_out_valid", a_out_valid, 1'b0);
        check("mrst_occ", a_occ, 2'd0);
        check("mrst_out_ctrl", a_out_ctrl, 16'h0000);
        check("mrst_drop", a_drop, 2'd0);
        check("mrst_in_ready", a_in_ready, 1'b0);
        qa.delete();
        a_in_valid = 0;
        #3 rst_n = 1'b1;
        cyc_a(1, 16'h0303, 128'h33, 1, 0, 0, 1, 0, 0);
        cyc_a(0, 16'h0000, 128'd0, 1, 0, 0, 1, 1, 1);
        cyc_a(0, 16'h0000, 128'd0, 1, 0, 0, 1, 0, 0);

        // SKID=0: in_ready follows out_ready when occupied
        cyc_b(0, 16'h0000, 128'd0, 0, 1, 0, 0);
        check("b_empty_ctrl", b_out_ctrl, B_RST);
        cyc_b(1, 16'h1111, 128'h11, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        b_in_valid = 1; b_in_ctrl = 16'h2222; b_in_data = 128'h22; b_out_ready = 0;
        #1;
        check("b_in_ready_blocked", b_in_ready, 1'b0);
        check("b_out_valid_held", b_out_valid, 1'b1);
        check("b_out_ctrl_head", b_out_ctrl, 16'h1111);
        #1 b_out_ready = 1;
        #1;
        check("b_in_ready_raised", b_in_ready, 1'b1);
        qb.push_back('{ctrl: 16'h2222, data: 128'h22});
        cyc_b(1, 16'h3333, 128'h33, 1, 1, 1, 1);
        cyc_b(1, 16'h4444, 128'h44, 1, 1, 1, 1);
        cyc_b(0, 16'h0000, 128'd0, 1, 1, 1, 1);
        cyc_b(0, 16'h0000, 128'd0, 1, 1, 0, 0);
        check("b_empty_ctrl_end", b_out_ctrl, B_RST);

        @(posedge clk);
        #4;
        check("a_pop_count", pops_a, 8);
        check("b_pop_count", pops_b, 4);
        check("a_queue_left", qa.size(), 0);
        check("b_queue_left", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
